// File: rtl/seq_detector_param_mealy_moore.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param_mealy_moore
// Description : Runtime-programmable serial pattern detector with selectable
//               overlap and Mealy/Moore output timing, plus a saturating
//               match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param_mealy_moore #(
    parameter int               SEQ_W       = 4,
    parameter logic [SEQ_W-1:0] DEFAULT_SEQ = 4'b0110,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             seq_load,
    input  logic [SEQ_W-1:0] seq_in,
    input  logic             overlap_en,
    input  logic             moore_mode,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_count
);

    localparam int                FILL_W   = (SEQ_W > 2) ? $clog2(SEQ_W) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [SEQ_W-1:0]  pattern_q, pattern_d;
    logic [SEQ_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              dout_q, dout_d;
    logic [CNT_W-1:0]  match_count_q, match_count_d;
    logic              overlap_q, moore_q;

    logic [SEQ_W-1:0]  w_window;
    logic              w_hit;
    logic              w_mode_chg;

    // Oldest held bit lines up with the pattern MSB.
    assign w_window   = {hist_q, din};
    assign w_hit      = din_valid & ~seq_load & (fill_q == FILL_MAX) & (w_window == pattern_q);
    assign w_mode_chg = (overlap_en != overlap_q) | (moore_mode != moore_q);

    always_comb begin
        pattern_d     = pattern_q;
        hist_d        = hist_q;
        fill_d        = fill_q;
        dout_d        = w_hit;
        match_count_d = match_count_q;

        if (seq_load) begin
            pattern_d = seq_in;
            fill_d    = '0;
            dout_d    = 1'b0;
        end else if (din_valid) begin
            hist_d = w_window[SEQ_W-2:0];
            if (w_hit && !overlap_en) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        // A mode switch restarts matching but still lets this cycle's hit count.
        if (w_mode_chg) begin
            fill_d = '0;
            dout_d = 1'b0;
        end

        if (cnt_clr) begin
            match_count_d = w_hit ? CNT_W'(1) : '0;
        end else if (w_hit && (match_count_q != CNT_MAX)) begin
            match_count_d = match_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_q     <= DEFAULT_SEQ;
            hist_q        <= '0;
            fill_q        <= '0;
            dout_q        <= 1'b0;
            match_count_q <= '0;
            overlap_q     <= overlap_en;
            moore_q       <= moore_mode;
        end else begin
            pattern_q     <= pattern_d;
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            dout_q        <= dout_d;
            match_count_q <= match_count_d;
            overlap_q     <= overlap_en;
            moore_q       <= moore_mode;
        end
    end

    assign dout        = reset & (moore_mode ? dout_q : w_hit);
    assign match_count = match_count_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param_mealy_moore.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_param_mealy_moore
// Description : Directed and randomized bench for the pattern detector, with
//               an 8-bit and a 2-bit counter instance sharing one stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param_mealy_moore;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       seq_load = 1'b0;
    logic [3:0] seq_in = 4'b0000;
    logic       overlap_en = 1'b1;
    logic       moore_mode = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       dout_a, dout_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    logic       g_ov = 1'b1;
    logic       g_mo = 1'b0;

    // Reference model: pattern plus the list of valid bits received since
    // the last restart point (reset, load, mode switch, non-overlap hit).
    logic [3:0] m_pat;
    int         m_q[$];
    logic       m_dq;
    int         m_cnt_a, m_cnt_b;
    logic       m_ov, m_mo;

    always #5 clk = ~clk;

    seq_detector_param_mealy_moore #(.SEQ_W(4), .DEFAULT_SEQ(4'b0110), .CNT_W(8)) u_dut_a (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .seq_load(seq_load), .seq_in(seq_in), .overlap_en(overlap_en),
        .moore_mode(moore_mode), .cnt_clr(cnt_clr), .dout(dout_a), .match_count(cnt_a)
    );

    seq_detector_param_mealy_moore #(.SEQ_W(4), .DEFAULT_SEQ(4'b0110), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .seq_load(seq_load), .seq_in(seq_in), .overlap_en(overlap_en),
        .moore_mode(moore_mode), .cnt_clr(cnt_clr), .dout(dout_b), .match_count(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hit(input logic v, input logic d, input logic ld);
        logic [3:0] w;
        int         n;
        n = m_q.size();
        if (!v || ld || n < 3) return 1'b0;
        w[3] = m_q[n-3][0];
        w[2] = m_q[n-2][0];
        w[1] = m_q[n-1][0];
        w[0] = d;
        return (w == m_pat);
    endfunction

    task automatic step(input logic v, input logic d, input logic ld,
                        input logic [3:0] si, input logic clr);
        logic h;
        @(negedge clk);
        din_valid  = v;
        din        = d;
        seq_load   = ld;
        seq_in     = si;
        cnt_clr    = clr;
        overlap_en = g_ov;
        moore_mode = g_mo;
        #1;
        h = model_hit(v, d, ld);
        check("dout_a", dout_a, moore_mode ? m_dq : h);
        check("dout_b", dout_b, moore_mode ? m_dq : h);
        check("cnt_a", cnt_a, m_cnt_a);
        check("cnt_b", cnt_b, m_cnt_b);
        @(posedge clk);
        m_dq = h;
        if (ld) begin
            m_pat = si;
            m_q.delete();
            m_dq = 1'b0;
        end else if (v) begin
            m_q.push_back(int'(d));
            if (h && !overlap_en) m_q.delete();
            if (m_q.size() > 16) void'(m_q.pop_front());
        end
        if ((overlap_en !== m_ov) || (moore_mode !== m_mo)) begin
            m_q.delete();
            m_dq = 1'b0;
            m_ov = overlap_en;
            m_mo = moore_mode;
        end
        if (clr) m_cnt_a = h ? 1 : 0;
        else if (h && m_cnt_a < 255) m_cnt_a++;
        if (clr) m_cnt_b = h ? 1 : 0;
        else if (h && m_cnt_b < 3) m_cnt_b++;
    endtask

    task automatic bit_in(input logic d);
        step(1'b1, d, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic bits_in(input string s);
        for (int i = 0; i < s.len(); i++) bit_in(s[i] == "1");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b0;
        din_valid  = 1'b0;
        seq_load   = 1'b0;
        cnt_clr    = 1'b0;
        overlap_en = g_ov;
        moore_mode = g_mo;
        m_pat   = 4'b0110;
        m_q.delete();
        m_dq    = 1'b0;
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_ov    = g_ov;
        m_mo    = g_mo;
        #1;
        check("rst_dout_a", dout_a, 0);
        check("rst_dout_b", dout_b, 0);
        check("rst_cnt_a", cnt_a, 0);
        @(posedge clk);
        #1;
        check("rst_hold_dout_a", dout_a, 0);
        check("rst_hold_cnt_b", cnt_b, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_cnt(input string tag, input int ea, input int eb);
        #1;
        check({tag, "_a"}, cnt_a, ea);
        check({tag, "_b"}, cnt_b, eb);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] pool [4];
        logic       ld, v, d, clr;
        logic [3:0] si;
        pool[0] = 4'b0110;
        pool[1] = 4'b1011;
        pool[2] = 4'b1111;
        pool[3] = 4'b0101;

        // Overlapping Mealy on the default pattern.
        g_ov = 1'b1; g_mo = 1'b0;
        do_reset();
        bits_in("0110110");
        check_cnt("ovl_mealy", 2, 2);

        // Non-overlapping, then a fresh second match.
        g_ov = 1'b0;
        do_reset();
        bits_in("0110110");
        check_cnt("novl_first", 1, 1);
        bits_in("0110");
        check_cnt("novl_second", 2, 2);

        // Overlapping Moore.
        g_ov = 1'b1; g_mo = 1'b1;
        do_reset();
        bits_in("0110110");
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        check_cnt("ovl_moore", 2, 2);

        // Runtime pattern load.
        g_mo = 1'b0;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
        bits_in("1011011");
        check_cnt("load_1011", 2, 2);
        step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
        bits_in("0110");
        check_cnt("load_nohit", 2, 2);

        // Valid gaps are transparent.
        do_reset();
        bits_in("01");
        repeat (3) step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        bits_in("10");
        check_cnt("gaps", 1, 1);

        // Reset mid-sequence discards history.
        do_reset();
        bits_in("011");
        do_reset();
        bits_in("0");
        check_cnt("mid_reset", 0, 0);

        // Saturation of the 2-bit counter, then clear on a hit cycle.
        do_reset();
        bits_in("0110110110110");
        check_cnt("saturate", 4, 3);
        bits_in("11");
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
        check_cnt("clr_on_hit", 1, 1);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        check_cnt("clr_alone", 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                g_ov = 1'($urandom);
                g_mo = 1'($urandom);
                do_reset();
            end else begin
                if ($urandom_range(0, 19) == 0) g_ov = ~g_ov;
                if ($urandom_range(0, 19) == 0) g_mo = ~g_mo;
                ld  = ($urandom_range(0, 29) == 0);
                si  = pool[$urandom_range(0, 3)];
                v   = ($urandom_range(0, 3) != 0);
                d   = 1'($urandom);
                clr = ($urandom_range(0, 39) == 0);
                step(v, d, ld, si, clr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detector_param_mealy_moore.md
Name: seq_detector_param_mealy_moore

Overview:
Runtime-programmable serial bit-sequence detector. Generalises the fixed 0110 overlapping Mealy detector:
- Pattern width is a parameter, and the pattern can be loaded at runtime.
- Overlapping or non-overlapping detection is selectable.
- Mealy or Moore output timing is selectable.
- A saturating match counter is included.
Sits on a serial input stream with a per-bit valid qualifier. Feeds event/interrupt logic.

Parameters:
SEQ_W, 4, pattern length in bits (>=2).
DEFAULT_SEQ, 4'b0110, pattern loaded at reset, SEQ_W bits wide.
CNT_W, 8, match counter width (>=1).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
din  input  1  serial data bit.
din_valid  input  1  din is sampled only when high.
seq_load  input  1  load seq_in into pattern register.
seq_in  input  SEQ_W  new pattern, MSB = first bit of sequence.
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
moore_mode  input  1  1 = registered (Moore) dout, 0 = combinational (Mealy) dout.
cnt_clr  input  1  synchronous clear of match_count.
dout  output  1  detection pulse.
match_count  output  CNT_W  saturating count of detections.

Behaviour:
- State:
  - pattern[SEQ_W-1:0]
  - history shift register hist[SEQ_W-2:0], newest bit at LSB
  - fill counter 0..SEQ_W-1 (valid bits held in hist)
  - registered dout_q
  - match_count
  - mode shadow regs for overlap_en and moore_mode
- Reset (reset=0, async):
  - pattern=DEFAULT_SEQ; hist=0; fill=0; dout_q=0; match_count=0; shadows take current inputs.
  - dout forced 0 while reset is low, in both modes.
- hit (combinational) = din_valid & !seq_load & (fill==SEQ_W-1) & ({hist,din}==pattern). The first-received bit is compared against pattern MSB.
- Valid bit (din_valid=1, seq_load=0), rising edge:
  - hist shifts left and takes din.
  - fill increments, saturating at SEQ_W-1.
  - If hit and overlap_en=0: fill clears to 0 (hist contents don't care). The next match needs SEQ_W fresh bits.
  - If hit and overlap_en=1: fill stays SEQ_W-1, so any overlap length is detected, not only 1 bit.
- din_valid=0: hist/fill hold. Gaps are transparent to the sequence.
- Mealy (moore_mode=0): dout = hit, combinational, same cycle as the completing bit.
- Moore (moore_mode=1): dout_q <= hit at every edge; dout = dout_q. The pulse appears one cycle after the completing bit, for exactly one cycle.
- seq_load=1 at an edge:
  - pattern <= seq_in; fill <= 0; dout_q <= 0.
  - din is ignored that cycle; no hit is possible.
  - seq_load takes precedence over din_valid.
- Mode change: if overlap_en or moore_mode differs from its shadow at an edge:
  - fill <= 0, dout_q <= 0, shadow updated.
  - The bit in that cycle is still shifted, but fill ends at 0.
  - Same cycle: the Mealy hit, if any, still counts.
- match_count:
  - Increments by 1 on each hit (at the completing edge in both modes).
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr and hit in the same cycle -> count becomes 1.
  - cnt_clr alone -> 0.
- Reset mid-sequence discards partial history. No match can span a reset or a pattern load.

Test Plan:
- Default pattern 0110, overlap_en=1, moore_mode=0, bits 0,1,1,0,1,1,0 -> dout high combinationally during bit 4 and bit 7; match_count=2.
- Same stream, overlap_en=0 -> dout high only during bit 4; match_count=1. Extend stream with 0,1,1,0 -> second hit on bit 11.
- Same stream, moore_mode=1, overlap_en=1 -> dout high in the cycles after bits 4 and 7, one cycle each. Never combinationally in the bit cycle.
- seq_load with seq_in=4'b1011, then bits 1,0,1,1,0,1,1 overlapping -> hits on bits 4 and 7. Bits 0,1,1,0 after load -> no hit.
- din_valid gaps: bits 0,1 then din_valid=0 for 3 cycles with din=1, then 1,0 -> single hit on the final bit. Reset pulsed low after 0,1,1, then bit 0 -> no hit; dout=0 and match_count=0 during and after reset.
- CNT_W=2, overlapping, stream 0110110110110 (4 hits) -> match_count saturates at 3. cnt_clr asserted on a hit cycle -> match_count=1.
